// File: rtl/femto_mem_pkg.sv
// Shared definitions for the femto memory path: RV32I width codes, LSU state
// encoding, default memory depth and the request legality check.
package femto_mem_pkg;

    localparam int DEFAULT_MEM_WORDS = 256;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RDW  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_t;

    // Width code illegal for the direction, misaligned, or word index past the memory.
    function automatic logic req_illegal(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int          mem_words
    );
        logic bad_f3;
        logic misaligned;
        logic out_of_range;
        bad_f3       = we ? (funct3 > F3_W) : ((funct3 == 3'd3) || (funct3 > F3_HU));
        misaligned   = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
                     || ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = {2'b00, addr[31:2]} >= $unsigned(mem_words);
        return bad_f3 | misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts/extends a load from a memory word and
// merges a byte or half of store data into a read word for read-modify-write.
module lsu_byte_lane
    import femto_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [31:0] shifted;
    logic [3:0]  byte_en;

    // Halves are always 2-byte aligned here, so a byte-granular shift serves both widths.
    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE_ID = 2'(gi);
            logic [7:0] src_byte;

            assign byte_en[gi] = (funct3 == F3_W)
                              || ((funct3 == F3_H) && (lane[1] == LANE_ID[1]))
                              || ((funct3 == F3_B) && (lane == LANE_ID));
            assign src_byte = (funct3 == F3_W) ? wdata[8*gi +: 8]
                            : (funct3 == F3_H) ? wdata[8*(gi%2) +: 8]
                            : wdata[7:0];
            assign merged_word[8*gi +: 8] = byte_en[gi] ? src_byte : rdata[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a single-port registered-read word memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import femto_mem_pkg::*;
#(
    parameter int MEM_WORDS = DEFAULT_MEM_WORDS
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_reg;
    lsu_state_t  state_next;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  lane_reg;
    logic [31:0] wdata_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;
    logic        accept;
    logic        req_bad;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid & req_ready;
    assign req_bad   = req_illegal(req_we, req_funct3, req_addr, MEM_WORDS);

    lsu_byte_lane u_lane (
        .funct3      (funct3_reg),
        .lane        (lane_reg),
        .rdata       (mem_rdata),
        .wdata       (wdata_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)
                        state_next = RESP;
                    else if (req_we && (req_funct3 == F3_W))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = RDW;
            RDW:     state_next = we_reg ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            funct3_reg     <= 3'd0;
            lane_reg       <= 2'd0;
            wdata_reg      <= 32'd0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg       <= req_we;
                funct3_reg   <= req_funct3;
                lane_reg     <= req_addr[1:0];
                wdata_reg    <= req_wdata;
                mem_addr_reg <= {req_addr[31:2], 2'b00};
            end
            // Full-word stores go straight from IDLE; sub-word stores write the merged word.
            if (state_next == WR)
                mem_wdata_reg <= (state_reg == IDLE) ? req_wdata : merged_word;
            // Only a rejected request reaches RESP directly from IDLE.
            if (state_next == RESP) begin
                resp_err_reg   <= (state_reg == IDLE);
                resp_rdata_reg <= ((state_reg == RDW) && !we_reg) ? load_data : 32'd0;
            end
        end
    end

    assign mem_rw     = (state_reg != WR);
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached registered-read memory, a word-level
// reference model, a per-cycle compare process, directed and random requests.
`timescale 1ns/1ps
module tb_load_store_unit;
    import femto_mem_pkg::*;

    localparam int MEM_WORDS = 256;
    localparam int AW        = $clog2(MEM_WORDS);

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rw     (mem_rw),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached memory (what the DUT talks to) and the reference copy.
    logic [31:0] ref_mem   [MEM_WORDS];
    logic [31:0] mem_array [MEM_WORDS];
    logic        preload;
    logic [31:0] widx;
    assign widx = {2'b00, mem_addr[31:2]};

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_array[i] <= ref_mem[i];
            mem_rdata <= 32'd0;
        end else if (widx < 32'(MEM_WORDS)) begin
            if (!mem_rw) mem_array[widx[AW-1:0]] <= mem_wdata;
            mem_rdata <= mem_array[widx[AW-1:0]];
        end else begin
            mem_rdata <= 32'd0;
        end
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Expectations for the request in flight (written by the driver).
    bit          checking = 0;
    bit          pending  = 0;
    int          acc_cyc, exp_resp_cyc, exp_wr_cyc;
    bit          exp_has_wr, exp_err, exp_is_load;
    logic [31:0] exp_rdata, exp_wword, exp_waddr;

    // Observations (written by the compare process).
    int          resp_count = 0;
    int          wr_count   = 0;
    int          last_resp_cyc;
    logic [31:0] last_rdata, last_wdata;
    logic        last_err;

    // Reference model: size/alignment/range rules and byte arithmetic on whole words.
    function automatic void model_req(
        input  bit          we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  bit          commit,
        output bit          err,
        output logic [31:0] rdata,
        output int          lat,
        output bit          has_wr,
        output logic [31:0] wword
    );
        int unsigned word_idx, off, size;
        logic [31:0] w, v, b;
        word_idx = addr >> 2;
        off      = addr % 4;
        size     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err      = we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7);
        if (addr % size != 0) err = 1;
        if (word_idx >= MEM_WORDS) err = 1;
        rdata  = 32'd0;
        has_wr = 0;
        wword  = 32'd0;
        lat    = 1;
        if (err) return;
        w = ref_mem[word_idx[AW-1:0]];
        if (!we) begin
            lat = 3;
            v   = w >> (8 * off);
            case (f3)
                3'd0: begin b = v & 32'hFF;   rdata = (b >= 128)   ? b - 256   : b; end
                3'd1: begin b = v & 32'hFFFF; rdata = (b >= 32768) ? b - 65536 : b; end
                3'd4: rdata = v & 32'hFF;
                3'd5: rdata = v & 32'hFFFF;
                default: rdata = w;
            endcase
        end else begin
            lat    = (size == 4) ? 2 : 4;
            has_wr = 1;
            wword  = w;
            for (int i = 0; i < int'(size); i++) wword[8*(off+i) +: 8] = wdata[8*i +: 8];
            if (commit) ref_mem[word_idx[AW-1:0]] = wword;
        end
    endfunction

    // Compare process: every cycle after reset, DUT outputs against the expectations.
    always @(negedge clk) begin
        if (checking) begin : cmp
            bit exp_rv;
            bit exp_w;
            exp_rv = pending && (cyc == exp_resp_cyc);
            exp_w  = pending && exp_has_wr && (cyc == exp_wr_cyc);
            if (!rst)
                chk("req_ready", 32'(req_ready), 32'(!(pending && cyc >= acc_cyc && cyc <= exp_resp_cyc)));
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("mem_rw", 32'(mem_rw), 32'(!exp_w));
            if (exp_rv) begin
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                if (exp_is_load || exp_err) chk("resp_rdata", resp_rdata, exp_rdata);
            end
            if (exp_w) begin
                chk("mem_wdata", mem_wdata, exp_wword);
                chk("mem_addr", mem_addr, exp_waddr);
            end
            if (resp_valid) begin
                resp_count++;
                last_resp_cyc = cyc;
                last_rdata    = resp_rdata;
                last_err      = resp_err;
            end
            if (!mem_rw) begin
                wr_count++;
                last_wdata = mem_wdata;
            end
        end
    end

    // Issue one request and wait for its response; called just after a rising edge.
    task automatic issue(
        input  bit          we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        output logic [31:0] got_rdata,
        output logic        got_err,
        output int          got_lat,
        output int          got_writes
    );
        int          rc, wc, k, lat, a;
        bit          e, hw;
        logic [31:0] rd, ww;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        model_req(we, f3, addr, wdata, 1'b1, e, rd, lat, hw, ww);
        a            = cyc + 1;
        acc_cyc      = a;
        exp_resp_cyc = cyc + lat;
        exp_wr_cyc   = cyc + lat - 1;
        exp_has_wr   = hw;
        exp_err      = e;
        exp_is_load  = !we;
        exp_rdata    = rd;
        exp_wword    = ww;
        exp_waddr    = {addr[31:2], 2'b00};
        pending      = 1;
        rc = resp_count;
        wc = wr_count;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        k = 0;
        // While busy, present junk requests that must be ignored; drop valid in RESP.
        while (resp_count == rc && k < 20) begin
            if (resp_valid) begin
                req_valid = 1'b0;
            end else begin
                req_valid  = 1'($urandom_range(0, 1));
                req_we     = 1'($urandom_range(0, 1));
                req_funct3 = 3'($urandom_range(0, 7));
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
            @(posedge clk); #1;
            k++;
        end
        req_valid = 1'b0;
        chk("resp_count", 32'(resp_count - rc), 32'd1);
        got_rdata  = last_rdata;
        got_err    = last_err;
        got_lat    = last_resp_cyc - a + 1;
        got_writes = wr_count - wc;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] g_rd;
        logic        g_err;
        int          g_lat, g_wr, rc, wc, bad, lat;
        bit          we, e, hw;
        logic [2:0]  f3;
        logic [31:0] addr, rd, ww;
        int unsigned r;

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
        ref_mem[1] = 32'h8899AABB;
        rst = 1'b1;
        preload = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        preload = 1'b0;
        checking = 1;

        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_rw", 32'(mem_rw), 32'd1);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        issue(1'b0, F3_B, 32'h7, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("lb7_rdata", g_rd, 32'hFFFFFF88);
        chk("lb7_err", 32'(g_err), 32'd0);
        chk("lb7_lat", 32'(g_lat), 32'd3);
        issue(1'b0, F3_BU, 32'h6, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("lbu6_rdata", g_rd, 32'h00000099);
        issue(1'b0, F3_HU, 32'h4, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("lhu4_rdata", g_rd, 32'h0000AABB);

        issue(1'b1, F3_B, 32'h5, 32'h123456CC, g_rd, g_err, g_lat, g_wr);
        chk("sb5_writes", 32'(g_wr), 32'd1);
        chk("sb5_wdata", last_wdata, 32'h8899CCBB);
        issue(1'b0, F3_W, 32'h4, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("lw4_rdata", g_rd, 32'h8899CCBB);

        issue(1'b1, F3_W, 32'h8, 32'hDEADBEEF, g_rd, g_err, g_lat, g_wr);
        chk("sw8_lat", 32'(g_lat), 32'd2);
        chk("sw8_writes", 32'(g_wr), 32'd1);
        issue(1'b0, F3_W, 32'h8, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("lw8_rdata", g_rd, 32'hDEADBEEF);

        issue(1'b0, F3_H, 32'h3, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("lh3_err", 32'(g_err), 32'd1);
        chk("lh3_lat", 32'(g_lat), 32'd1);
        chk("lh3_writes", 32'(g_wr), 32'd0);
        issue(1'b1, F3_W, 32'h6, 32'h11111111, g_rd, g_err, g_lat, g_wr);
        chk("sw6_err", 32'(g_err), 32'd1);
        chk("sw6_lat", 32'(g_lat), 32'd1);
        chk("sw6_writes", 32'(g_wr), 32'd0);
        issue(1'b0, F3_W, 32'h400, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("lw400_err", 32'(g_err), 32'd1);
        chk("lw400_lat", 32'(g_lat), 32'd1);
        chk("lw400_rdata", g_rd, 32'd0);
        issue(1'b0, F3_W, 32'h3FC, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("lw3fc_err", 32'(g_err), 32'd0);
        issue(1'b0, 3'd3, 32'h4, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("ld_f3_3_err", 32'(g_err), 32'd1);
        issue(1'b1, 3'd4, 32'h4, 32'h0, g_rd, g_err, g_lat, g_wr);
        chk("st_f3_4_err", 32'(g_err), 32'd1);
        chk("st_f3_4_writes", 32'(g_wr), 32'd0);

        // SH at 0x4 abandoned by a reset pulse in RDW; the model is not committed.
        rc = resp_count;
        wc = wr_count;
        model_req(1'b1, F3_H, 32'h4, 32'h0000BEEF, 1'b0, e, rd, lat, hw, ww);
        acc_cyc = cyc + 1; exp_resp_cyc = cyc + lat; exp_wr_cyc = cyc + lat - 1;
        exp_has_wr = hw; exp_err = e; exp_is_load = 0; exp_rdata = rd; exp_wword = ww;
        exp_waddr = 32'h4; pending = 1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h4; req_wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        pending = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_writes", 32'(wr_count - wc), 32'd0);
        chk("abort_resps", 32'(resp_count - rc), 32'd0);
        chk("abort_word1", mem_array[1], ref_mem[1]);

        // Reset coincident with a valid request: the request must be dropped.
        rc = resp_count;
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h4;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        chk("rstreq_ready", 32'(req_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("rstreq_resps", 32'(resp_count - rc), 32'd0);

        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r < 8) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else begin
                    r  = $urandom_range(0, 4);
                    f3 = (r > 2) ? 3'(r + 1) : 3'(r);
                end
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                if (f3[1]) addr[1:0] = 2'b00;
                else if (f3[0]) addr[0] = 1'b0;
            end
            issue(we, f3, addr, $urandom, g_rd, g_err, g_lat, g_wr);
        end

        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem_array[i] !== ref_mem[i]) bad++;
        chk("mem_final_bad_words", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, number of 32-bit words in the attached memory; a word index >= MEM_WORDS is out of range.
REQ-002 SHALL have ports: clk input 1, the single clock; rst input 1, synchronous active-high reset.
REQ-003 req_valid input 1: request present.
REQ-004 req_ready output 1: unit accepts a request this cycle.
REQ-005 req_we input 1: 1 = store, 0 = load.
REQ-006 req_funct3 input 3: RV32I width code (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
REQ-007 req_addr input 32: byte address.
REQ-008 req_wdata input 32: store data, right-aligned.
REQ-009 resp_valid output 1: one-cycle completion pulse.
REQ-010 resp_rdata output 32: load result, extended to 32 bits.
REQ-011 resp_err output 1: request rejected (misaligned, out of range, or illegal funct3).
REQ-012 mem_addr output 32: word-aligned byte address to memory, bits [1:0] = 0.
REQ-013 mem_wdata output 32: write word to memory.
REQ-014 mem_rw output 1: low = write, high = read.
REQ-015 mem_rdata input 32: memory read word, registered by memory and valid the cycle after the read address was presented with mem_rw high.

Function
REQ-016 FSM states SHALL be IDLE, RD, RDW, WR, RESP.
- req_ready = (state == IDLE).
- A request is accepted on a clk edge with req_valid & req_ready.
- All request fields are registered at acceptance; request inputs are ignored outside IDLE.
REQ-017 Load path SHALL be IDLE->RD->RDW->RESP->IDLE.
- RD: mem_addr = {addr[31:2],2'b00}, mem_rw = 1.
- RDW: lane-extract mem_rdata into a result register.
- RESP: resp_valid = 1.
REQ-018 SW path SHALL be IDLE->WR->RESP. WR drives mem_rw = 0 with mem_wdata = req_wdata for exactly one cycle.
REQ-019 SB/SH path SHALL be IDLE->RD->RDW->WR->RESP (read-modify-write).
- RDW merges the target byte or half of req_wdata into mem_rdata.
- Byte lane = addr[1:0]; half lane = addr[1].
- WR writes the merged word.
REQ-020 Load extension SHALL be: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-021 Errors SHALL be detected at acceptance and take path IDLE->RESP with resp_err = 1, resp_rdata = 0, and no mem_rw low cycle. Error conditions:
- LH/LHU/SH with addr[0] = 1;
- LW/SW with addr[1:0] != 0;
- addr[31:2] >= MEM_WORDS;
- load funct3 in {3,6,7}, or store funct3 >= 3.
REQ-022 Outside WR, mem_rw SHALL be 1; mem_wdata SHALL hold its last value; mem_addr SHALL hold the latched word address.
REQ-023 resp_err and resp_rdata SHALL be valid only while resp_valid = 1 and SHALL hold until the next response. There is no response backpressure.
REQ-024 A back-to-back request SHALL be accepted no earlier than the IDLE cycle following RESP.

Reset
REQ-025 On rst high at a clk edge: state = IDLE, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_rw = 1, mem_addr = 0, mem_wdata = 0.
REQ-026 rst SHALL override a coincident req_valid; that request is not accepted.
REQ-027 Reset mid-operation SHALL abandon the access without issuing a response.
- A WR cycle coinciding with rst high still commits at that edge, since mem_rw is decoded from state.
- No write is issued after reset.

Structure
REQ-028 A shared package femto_mem_pkg SHALL hold the funct3 constants, the FSM state enum, and the default MEM_WORDS.
REQ-029 Lane extract/merge logic SHALL be one combinational sub-module, lsu_byte_lane; the FSM stays in load_store_unit.

Verification
Preload word 1 (byte address 0x4) = 0x8899AABB.
REQ-030 LB at 0x7 -> resp_valid on the 3rd edge after acceptance, resp_rdata = 0xFFFFFF88, resp_err = 0.
REQ-031 LBU at 0x6 -> resp_rdata = 0x00000099; LHU at 0x4 -> 0x0000AABB.
REQ-032 SB at 0x5, wdata 0x123456CC -> exactly one mem_rw low cycle with mem_wdata = 0x8899CCBB; a following LW at 0x4 returns 0x8899CCBB.
REQ-033 SW at 0x8, wdata 0xDEADBEEF -> resp_valid on the 2nd edge after acceptance; LW at 0x8 then returns 0xDEADBEEF.
REQ-034 LH at 0x3, SW at 0x6, and LW at 0x400 (with MEM_WORDS = 256) -> each yields resp_err = 1 on the 1st edge after acceptance, with no mem_rw low cycle.
REQ-035 SH at 0x4 with rst pulsed during RDW -> no mem_rw low cycle, no resp_valid, req_ready = 1 on the following cycle; memory word 1 unchanged.
